// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-port request/grant access to a DEPTH x DATA_W register bank, two cycles per access.
// Define REGFILE_ARB_FIXED_PRIO_EN to make port B always win contention instead of round-robin.
module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we_q, port_q, take, pick_b;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
  logic prio_b;
`endif
  assign busy = state_q == GRANT;
  always_comb begin
    take = (state_q == IDLE) && (req_a || req_b);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    pick_b = req_b;
`else
    pick_b = req_b && (!req_a || prio_b);
`endif
    state_d = take ? GRANT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      mem      <= '{default: '0};
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      prio_b   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_a    <= take && !pick_b;
      gnt_b    <= take && pick_b;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      if (take) begin
        port_q  <= pick_b;
        we_q    <= pick_b ? we_b : we_a;
        addr_q  <= pick_b ? addr_b : addr_a;
        wdata_q <= pick_b ? wdata_b : wdata_a;
      end
      if (state_q == GRANT) begin
        if (we_q) mem[addr_q] <= wdata_q;
        else if (port_q) begin
          rdata_b  <= mem[addr_q];
          rvalid_b <= 1'b1;
        end else begin
          rdata_a  <= mem[addr_q];
          rvalid_a <= 1'b1;
        end
`ifndef REGFILE_ARB_FIXED_PRIO_EN
        prio_b <= !port_q;
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed stimulus, per-cycle compare against a transaction-level model plus literal checks.
module tb_regfile_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req_a = 0, req_b = 0, we_a = 0, we_b = 0;
  logic [2:0] addr_a = 0, addr_b = 0;
  logic [15:0] wdata_a = 0, wdata_b = 0;
  logic gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [15:0] rdata_a, rdata_b;
  int checks = 0, errors = 0;

  regfile_arbiter dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one pending transaction at a time, remembering which port was served last.
  bit m_on = 0, m_busy = 0, m_port = 0, m_we = 0, m_last_b = 1, win;
  logic [2:0] m_addr;
  logic [15:0] m_wdata, m_mem [8];
  bit e_gnt_a, e_gnt_b, e_rv_a, e_rv_b;
  logic [15:0] e_rd_a, e_rd_b;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_busy = 0; m_last_b = 1;
      e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0; e_rd_a = 0; e_rd_b = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0;
      if (m_busy) begin
        if (m_we) m_mem[m_addr] = m_wdata;
        else if (m_port) begin e_rd_b = m_mem[m_addr]; e_rv_b = 1; end
        else begin e_rd_a = m_mem[m_addr]; e_rv_a = 1; end
        m_busy = 0;
        m_last_b = m_port;
      end else if (req_a || req_b) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        win = req_b;
`else
        win = (req_a && req_b) ? !m_last_b : req_b;
`endif
        m_port = win; m_busy = 1;
        m_we = win ? we_b : we_a;
        m_addr = win ? addr_b : addr_a;
        m_wdata = win ? wdata_b : wdata_a;
        if (win) e_gnt_b = 1; else e_gnt_a = 1;
      end
    end
  end

  always @(negedge clk) if (m_on) begin
    chk("gnt_a", 16'(gnt_a), 16'(e_gnt_a));
    chk("gnt_b", 16'(gnt_b), 16'(e_gnt_b));
    chk("rvalid_a", 16'(rvalid_a), 16'(e_rv_a));
    chk("rvalid_b", 16'(rvalid_b), 16'(e_rv_b));
    chk("rdata_a", rdata_a, e_rd_a);
    chk("rdata_b", rdata_b, e_rd_b);
    chk("busy", 16'(busy), 16'(m_busy));
  end

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  // Drive one request, wait (bounded) for its grant, then let the access complete.
  task automatic acc(input bit pb, input bit w, input logic [2:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    if (pb) begin req_b = 1; we_b = w; addr_b = a; wdata_b = d; end
    else begin req_a = 1; we_a = w; addr_a = a; wdata_a = d; end
    do begin @(negedge clk); n++; end while (!(pb ? gnt_b : gnt_a) && n < 8);
    chk(pb ? "grant_b_seen" : "grant_a_seen", 16'(pb ? gnt_b : gnt_a), 16'd1);
    req_a = 0; req_b = 0;
    @(negedge clk);
  endtask

  bit seq [$];
  bit exp_seq [4];

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_gnt", 16'({gnt_a, gnt_b, rvalid_a, rvalid_b, busy}), 16'd0);
    chk("rst_rdata_a", rdata_a, 16'h0000);
    chk("rst_rdata_b", rdata_b, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      acc(0, 0, 3'(i), 0);
      chk("read_all_rvalid_a", 16'(rvalid_a), 16'd1);
      chk("read_all_rdata_a", rdata_a, 16'h0000);
    end
    acc(1, 1, 3'd5, 16'hBEEF);
    chk("wr_b_no_rvalid", 16'(rvalid_b), 16'd0);
    acc(0, 0, 3'd5, 0);
    chk("rd_r5_rdata_a", rdata_a, 16'hBEEF);
    chk("rd_r5_rdata_b", rdata_b, 16'h0000);
    do_reset();
    @(negedge clk);
    req_a = 1; req_b = 1; we_a = 0; we_b = 0; addr_a = 3'd1; addr_b = 3'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt_a) seq.push_back(0);
      if (gnt_b) seq.push_back(1);
    end
    req_a = 0; req_b = 0;
    @(negedge clk);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    exp_seq = '{1, 1, 1, 1};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    chk("alt_grant_count", 16'(seq.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      chk("alt_grant_port", 16'(i < seq.size() ? seq[i] : 1'bx), 16'(exp_seq[i]));
    @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 3'd2; wdata_a = 16'h1234;
    @(negedge clk);
    chk("abort_gnt_a", 16'(gnt_a), 16'd1);
    req_a = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_no_rvalid", 16'({rvalid_a, rvalid_b}), 16'd0);
    acc(0, 0, 3'd2, 0);
    chk("abort_r2", rdata_a, 16'h0000);
    do_reset();
    acc(1, 1, 3'd3, 16'h00AA);
    @(negedge clk);
    req_a = 1; we_a = 0; addr_a = 3'd3;
    req_b = 1; we_b = 1; addr_b = 3'd3; wdata_b = 16'h5555;
    @(negedge clk);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    chk("contend_first_b", 16'(gnt_b), 16'd1);
    req_b = 0;
    @(negedge clk);
    @(negedge clk);
    chk("contend_then_a", 16'(gnt_a), 16'd1);
    req_a = 0;
    @(negedge clk);
    chk("contend_rdata_a", rdata_a, 16'h5555);
`else
    chk("contend_first_a", 16'(gnt_a), 16'd1);
    req_a = 0;
    @(negedge clk);
    chk("contend_rdata_a", rdata_a, 16'h00AA);
    @(negedge clk);
    chk("contend_then_b", 16'(gnt_b), 16'd1);
    req_b = 0;
    @(negedge clk);
    acc(0, 0, 3'd3, 0);
    chk("contend_reread", rdata_a, 16'h5555);
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
